// File: rtl/y_to_strip_id.sv
// y_to_strip_id: 4-step binary search mapping row y to strip ID and offset within that strip.
// Optional Y2S_RANGE_CHECK_EN flags y >= 128 with err_o instead of folding it into strip 13.
module y_to_strip_id (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] y_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic [3:0] strip_id_o,
    output logic [3:0] offset_o,
    output logic       err_o,
    output logic       out_valid_o,
    input  logic       out_ready_i
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    state_t state, state_nxt;
    logic [7:0] y;
    logic [3:0] lo, hi, lo_nxt, hi_nxt, mid;
    logic [4:0] sum;
    logic [1:0] step;
    logic [7:0] diff;
    function automatic logic [7:0] start(input logic [3:0] k);
        if (k >= 4'd12)
            return {k, 4'b0000} - 8'd96;
        if (k[0])
            return {1'b0, k - 4'd1, 3'b000};
        return {1'b0, k, 3'b000} - (8'd9 - {5'b00000, k[3:1]});
    endfunction
    // sum is one bit wider so lo + hi + 1 cannot wrap before halving
    assign sum = {1'b0, lo} + {1'b0, hi} + 5'd1;
    assign mid = sum[4:1];
    assign diff = y - start(lo_nxt);
    assign in_ready_o = (state == IDLE) && !rst_i;
    assign out_valid_o = (state == DONE);
    always_comb begin
        lo_nxt = lo;
        hi_nxt = hi;
        if (lo != hi) begin
            if (start(mid) <= y)
                lo_nxt = mid;
            else
                hi_nxt = mid - 4'd1;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid_i ? SEARCH : IDLE;
            SEARCH:  state_nxt = (step == 2'd3) ? DONE : SEARCH;
            DONE:    state_nxt = out_ready_i ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            y          <= 8'd0;
            lo         <= 4'd0;
            hi         <= 4'd0;
            step       <= 2'd0;
            strip_id_o <= 4'd0;
            offset_o   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid_i) begin
                y    <= y_i;
                lo   <= 4'd1;
                hi   <= 4'd13;
                step <= 2'd0;
            end
            if (state == SEARCH) begin
                lo   <= lo_nxt;
                hi   <= hi_nxt;
                step <= step + 2'd1;
                if (step == 2'd3) begin
`ifdef Y2S_RANGE_CHECK_EN
                    strip_id_o <= y[7] ? 4'd0 : lo_nxt;
                    offset_o   <= y[7] ? 4'd0 : diff[3:0];
`else
                    strip_id_o <= lo_nxt;
                    offset_o   <= diff[3:0];
`endif
                end
            end
        end
    end
`ifdef Y2S_RANGE_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_o <= 1'b0;
        else if (state == SEARCH && step == 2'd3)
            err_o <= y[7];
    end
`else
    assign err_o = 1'b0;
`endif
endmodule
